// File: rtl/traffic_pkg.sv
// traffic_pkg: lamp codes, phases and fault codes shared by the controller and the checker
package traffic_pkg;
  localparam logic [2:0] GREEN = 3'b101;
  localparam logic [2:0] YELLOW = 3'b001;
  localparam logic [2:0] RED = 3'b011;
  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b100;
  typedef enum logic [1:0] {PH_RED, PH_GREEN, PH_YELLOW} phase_t;
  typedef enum logic [2:0] {FC_NONE, FC_INVALID, FC_CONFLICT, FC_SEQ, FC_YELLOW} fault_code_t;
endpackage

// File: rtl/traffic_phase_tracker.sv
// traffic_phase_tracker: per-direction decode, phase order check and yellow duration timer
module traffic_phase_tracker
  import traffic_pkg::*;
#(
  parameter int YELLOW_MIN = 5,
  parameter int YELLOW_MAX = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic [2:0] code,
  input  logic       prev_valid,
  output logic [2:0] lamp,
  output logic       is_red,
  output logic       invalid,
  output logic       seq_err,
  output logic       yellow_err,
  output logic       r2g
);
  localparam int TW = $clog2(YELLOW_MAX + 2);
  phase_t r_phase, w_phase;
  logic [TW-1:0] r_ycnt, w_ycnt;
  logic w_yel, w_chk;
  always_comb begin
    invalid = code != GREEN && code != YELLOW && code != RED;
    w_phase = code == GREEN ? PH_GREEN : code == YELLOW ? PH_YELLOW : PH_RED;
    lamp = invalid ? LAMP_R : w_phase == PH_GREEN ? LAMP_G : w_phase == PH_YELLOW ? LAMP_Y : LAMP_R;
    is_red = !invalid && w_phase == PH_RED;
    w_yel = !invalid && w_phase == PH_YELLOW;
    w_ycnt = r_ycnt == TW'(YELLOW_MAX + 1) ? r_ycnt : r_ycnt + 1'b1;
    // order and short-yellow checks need a trusted previous phase
    w_chk = prev_valid && !invalid;
    seq_err = w_chk && ((r_phase == PH_GREEN && w_phase == PH_RED) ||
                        (r_phase == PH_YELLOW && w_phase == PH_GREEN) ||
                        (r_phase == PH_RED && w_phase == PH_YELLOW));
    yellow_err = (w_yel && w_ycnt > TW'(YELLOW_MAX)) ||
                 (w_chk && r_phase == PH_YELLOW && !w_yel && r_ycnt < TW'(YELLOW_MIN));
    r2g = w_chk && r_phase == PH_RED && w_phase == PH_GREEN;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_phase <= PH_RED;
      r_ycnt <= '0;
    end else begin
      if (!invalid) r_phase <= w_phase;
      r_ycnt <= (clr || !w_yel) ? '0 : w_ycnt;
    end
  end
endmodule

// File: rtl/traffic_lamp_checker.sv
// traffic_lamp_checker: decodes La/Lb lamp codes, latches the first protocol fault and forces all-red
module traffic_lamp_checker
  import traffic_pkg::*;
#(
  parameter int YELLOW_MIN = 5,
  parameter int YELLOW_MAX = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       La,
  input  logic [2:0]       Lb,
  input  logic             fault_clr,
  output logic [2:0]       lamp_a,
  output logic [2:0]       lamp_b,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic [CNT_W-1:0] cycle_cnt
);
  logic [2:0] w_lamp_a, w_lamp_b, r_lamp_a, r_lamp_b;
  logic w_red_a, w_red_b, w_inv_a, w_inv_b, w_seq_a, w_seq_b, w_yel_a, w_yel_b, w_r2g_a, w_r2g_b;
  logic w_conflict, w_latch, w_fault_nxt, r_fault, r_prev_valid;
  fault_code_t w_code, r_code;
  logic [CNT_W-1:0] r_cnt;
  traffic_phase_tracker #(.YELLOW_MIN(YELLOW_MIN), .YELLOW_MAX(YELLOW_MAX)) u_trk_a (
    .clk(clk), .reset_n(reset_n), .clr(fault_clr), .code(La), .prev_valid(r_prev_valid),
    .lamp(w_lamp_a), .is_red(w_red_a), .invalid(w_inv_a), .seq_err(w_seq_a),
    .yellow_err(w_yel_a), .r2g(w_r2g_a)
  );
  traffic_phase_tracker #(.YELLOW_MIN(YELLOW_MIN), .YELLOW_MAX(YELLOW_MAX)) u_trk_b (
    .clk(clk), .reset_n(reset_n), .clr(fault_clr), .code(Lb), .prev_valid(r_prev_valid),
    .lamp(w_lamp_b), .is_red(w_red_b), .invalid(w_inv_b), .seq_err(w_seq_b),
    .yellow_err(w_yel_b), .r2g(w_r2g_b)
  );
  always_comb begin
    w_conflict = !w_inv_a && !w_inv_b && !w_red_a && !w_red_b;
    w_code = (w_inv_a || w_inv_b) ? FC_INVALID : w_conflict ? FC_CONFLICT :
             (w_seq_a || w_seq_b) ? FC_SEQ : (w_yel_a || w_yel_b) ? FC_YELLOW : FC_NONE;
    // a fault seen in the clearing sample re-latches instead of being cleared
    w_latch = w_code != FC_NONE && (!r_fault || fault_clr);
    w_fault_nxt = w_latch || (r_fault && !fault_clr);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_fault <= 1'b0;
      r_code <= FC_NONE;
      r_prev_valid <= 1'b0;
      r_lamp_a <= LAMP_R;
      r_lamp_b <= LAMP_R;
      r_cnt <= '0;
    end else begin
      if (w_latch) begin
        r_fault <= 1'b1;
        r_code <= w_code;
      end else if (fault_clr) begin
        r_fault <= 1'b0;
        r_code <= FC_NONE;
      end
      r_prev_valid <= fault_clr ? 1'b0 : r_prev_valid || (!w_inv_a && !w_inv_b);
      r_lamp_a <= w_fault_nxt ? LAMP_R : w_lamp_a;
      r_lamp_b <= w_fault_nxt ? LAMP_R : w_lamp_b;
      if (w_r2g_a && !w_fault_nxt && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end
  assign lamp_a = r_lamp_a;
  assign lamp_b = r_lamp_b;
  assign fault = r_fault;
  assign fault_code = r_code;
  assign cycle_cnt = r_cnt;
endmodule

// File: tb/tb_traffic_lamp_checker.sv
// tb_traffic_lamp_checker: directed vectors with hand-computed expectations
module tb_traffic_lamp_checker;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] La = 3'b011;
  logic [2:0] Lb = 3'b011;
  logic fault_clr = 1'b0;
  logic [2:0] lamp_a, lamp_b, fault_code;
  logic fault;
  logic [15:0] cycle_cnt;
  int n_checks = 0;
  int n_errors = 0;
  traffic_lamp_checker dut (
    .clk(clk), .reset_n(reset_n), .La(La), .Lb(Lb), .fault_clr(fault_clr),
    .lamp_a(lamp_a), .lamp_b(lamp_b), .fault(fault), .fault_code(fault_code), .cycle_cnt(cycle_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic [2:0] a, input logic [2:0] b, input logic clr = 1'b0);
    La = a;
    Lb = b;
    fault_clr = clr;
    @(posedge clk);
    #1;
    fault_clr = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (2) step(3'b011, 3'b011);
    check("rst_lamp_a", lamp_a, 3'b100);
    check("rst_lamp_b", lamp_b, 3'b100);
    check("rst_fault", fault, 0);
    check("rst_code", fault_code, 0);
    check("rst_cnt", cycle_cnt, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(3'b101, 3'b011);
      check("t1_lamp_a", lamp_a, 3'b001);
      check("t1_lamp_b", lamp_b, 3'b100);
      check("t1_fault", fault, 0);
    end
    repeat (7) step(3'b101, 3'b011);
    repeat (5) step(3'b001, 3'b011);
    check("t2_a_yellow", lamp_a, 3'b010);
    repeat (10) step(3'b011, 3'b101);
    check("t2_b_green", lamp_b, 3'b001);
    repeat (5) step(3'b011, 3'b001);
    step(3'b011, 3'b011);
    step(3'b101, 3'b011);
    check("t2_fault", fault, 0);
    check("t2_cnt", cycle_cnt, 1);
    check("t2_lamp_a", lamp_a, 3'b001);
    step(3'b011, 3'b011);
    check("t3_fault", fault, 1);
    check("t3_code", fault_code, 3);
    check("t3_lamp_a", lamp_a, 3'b100);
    check("t3_lamp_b", lamp_b, 3'b100);
    step(3'b101, 3'b011);
    check("t3_forced_red", lamp_a, 3'b100);
    check("t3_cnt_hold", cycle_cnt, 1);
    step(3'b101, 3'b011, 1'b1);
    check("t3_clr_fault", fault, 0);
    check("t3_clr_lamp_a", lamp_a, 3'b001);
    step(3'b101, 3'b101);
    check("t4_conflict", fault_code, 2);
    check("t4_fault", fault, 1);
    step(3'b000, 3'b101);
    check("t4_sticky_code", fault_code, 2);
    step(3'b101, 3'b101, 1'b1);
    check("t4_clr_vs_det_fault", fault, 1);
    check("t4_clr_vs_det_code", fault_code, 2);
    step(3'b011, 3'b011, 1'b1);
    check("t4_clr2", fault, 0);
    step(3'b011, 3'b101);
    check("t4_pre_prio", fault, 0);
    step(3'b000, 3'b011);
    check("t4_priority", fault_code, 1);
    step(3'b011, 3'b011, 1'b1);
    check("t4_clr3", fault, 0);
    step(3'b011, 3'b011);
    step(3'b101, 3'b011);
    check("t5_cnt2", cycle_cnt, 2);
    repeat (4) step(3'b001, 3'b011);
    check("t5_short_pending", fault, 0);
    step(3'b011, 3'b011);
    check("t5_short", fault_code, 4);
    step(3'b011, 3'b011, 1'b1);
    check("t5_clr", fault, 0);
    step(3'b101, 3'b011);
    check("t5_cnt_resync", cycle_cnt, 2);
    repeat (5) step(3'b001, 3'b011);
    check("t5_y5_fault", fault, 0);
    check("t5_y5_lamp", lamp_a, 3'b010);
    step(3'b001, 3'b011);
    check("t5_long", fault_code, 4);
    check("t5_long_lamp", lamp_a, 3'b100);
    step(3'b011, 3'b011, 1'b1);
    check("t6_clr", fault, 0);
    step(3'b001, 3'b011);
    check("t6_resync_fault", fault, 0);
    check("t6_resync_lamp", lamp_a, 3'b010);
    step(3'b001, 3'b011);
    reset_n = 1'b0;
    step(3'b001, 3'b011);
    check("t6_rst_lamp_a", lamp_a, 3'b100);
    check("t6_rst_fault", fault, 0);
    check("t6_rst_code", fault_code, 0);
    check("t6_rst_cnt", cycle_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
